// File: rtl/serv_pc_pkg.sv
// rtl/serv_pc_pkg.sv - shared states, constants and sizing helpers for serv_pc_ctrl
package serv_pc_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    IDLE  = 2'd1,
    SHIFT = 2'd2
  } pc_state_e;

  localparam int XLEN = 32;

  // PC increments for compressed and full-length instructions
  localparam logic [31:0] INC2 = 32'd2;
  localparam logic [31:0] INC4 = 32'd4;

  // U-type immediates only carry bits at and above this position
  localparam int          UMASK_LO = 12;
  localparam logic [31:0] UMASK    = ~((32'd1 << UMASK_LO) - 32'd1);

  // Number of slice cycles per PC update for slice width w
  function automatic int slice_count(input int w);
    return XLEN / w;
  endfunction

  // Width of the slice counter for slice width w
  function automatic int cnt_width(input int w);
    return (XLEN / w > 1) ? $clog2(XLEN / w) : 1;
  endfunction

endpackage

// File: rtl/serv_slice_add.sv
// rtl/serv_slice_add.sv - W-bit slice adder with carry held between slices
module serv_slice_add #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  logic         carry;
  logic [W:0]   full;

  assign full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, carry};
  assign sum  = full[W-1:0];

  // Carry from the previous slice; cleared before the first slice of an update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry <= 1'b0;
    end else if (clr) begin
      carry <= 1'b0;
    end else if (en) begin
      carry <= full[W];
    end
  end

endmodule

// File: rtl/serv_pc_ctrl.sv
// rtl/serv_pc_ctrl.sv - slice-serial PC unit with fetch handshake; optional SERV_PC_CTRL_MISALIGN_EN
module serv_pc_ctrl
  import serv_pc_pkg::*;
#(
  parameter int          W        = 1,
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter bit          WITH_CSR = 1'b1,
  parameter bit          WITH_C   = 1'b1
) (
  input  logic         clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic         i_jump,
  input  logic         i_jal_or_jalr,
  input  logic         i_utype,
  input  logic         i_pc_rel,
  input  logic         i_trap,
  input  logic         i_iscomp,
  input  logic [W-1:0] i_imm,
  input  logic [W-1:0] i_buf,
  input  logic [W-1:0] i_csr_pc,
  output logic [W-1:0] o_rd,
  output logic [W-1:0] o_bad_pc,
`ifdef SERV_PC_CTRL_MISALIGN_EN
  output logic         o_misalign,
`endif
  output logic         o_busy,
  output logic         o_done,
  output logic [31:0]  o_ibus_adr,
  output logic         o_ibus_cyc,
  input  logic         i_ibus_ack
);

  localparam int                N        = slice_count(W);
  localparam int                CNT_W    = cnt_width(W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N - 1);

  pc_state_e        state;
  pc_state_e        state_d;
  logic [31:0]      pc_sh;
  logic [31-W:0]    pc_acc;
  logic [31:0]      pc_new;
  logic [CNT_W-1:0] cnt;
  logic [5:0]       bit_pos;
  logic [31:0]      inc_val;
  logic [W-1:0]     inc_sl;
  logic [W-1:0]     pc_sl;
  logic [W-1:0]     imm_sl;
  logic [W-1:0]     csr_sl;
  logic [W-1:0]     pc4_sl;
  logic [W-1:0]     tgt_raw;
  logic [W-1:0]     tgt_sl;
  logic [W-1:0]     new_sl;
  logic             shifting;
  logic             starting;
  logic             last;
  logic             trap_en;
  logic             misalign_hit;

  assign shifting = (state == SHIFT);
  assign starting = (state == IDLE) && i_start;
  assign last     = shifting && (cnt == CNT_LAST);
  assign trap_en  = WITH_CSR && i_trap;

  // Constants and masks are shifted down to the bit position of the current slice
  assign bit_pos = 6'(cnt) * 6'(W);
  assign inc_val = (WITH_C && i_iscomp) ? INC2 : INC4;
  assign inc_sl  = W'(inc_val >> bit_pos);
  assign pc_sl   = pc_sh[W-1:0];
  assign imm_sl  = i_imm & W'(UMASK >> bit_pos);
  assign csr_sl  = i_csr_pc & W'(32'hFFFF_FFFC >> bit_pos);
  assign tgt_sl  = tgt_raw & W'(32'hFFFF_FFFE >> bit_pos);

  serv_slice_add #(.W(W)) u_pc4 (
    .clk   (clk),
    .rst_n (i_rst_n),
    .clr   (starting),
    .en    (shifting),
    .a     (pc_sl),
    .b     (inc_sl),
    .sum   (pc4_sl)
  );

  serv_slice_add #(.W(W)) u_tgt (
    .clk   (clk),
    .rst_n (i_rst_n),
    .clr   (starting),
    .en    (shifting),
    .a     (i_pc_rel ? pc_sl : {W{1'b0}}),
    .b     (i_utype ? imm_sl : i_buf),
    .sum   (tgt_raw)
  );

  assign new_sl = trap_en ? csr_sl : (i_jump ? tgt_sl : pc4_sl);
  assign pc_new = {new_sl, pc_acc};

  assign o_rd     = shifting ? (({W{i_utype}} & tgt_sl) | ({W{i_jal_or_jalr}} & pc4_sl)) : {W{1'b0}};
  assign o_bad_pc = shifting ? tgt_sl : {W{1'b0}};

`ifdef SERV_PC_CTRL_MISALIGN_EN
  // Without compressed support a target on a 2-byte boundary cannot be fetched
  assign misalign_hit = last && i_jump && !trap_en && !WITH_C && pc_new[1];
`else
  assign misalign_hit = 1'b0;
`endif

  assign o_busy     = (state != IDLE);
  assign o_ibus_cyc = (state == FETCH);

  // State register; reset lands in FETCH so the reset vector is requested first
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= FETCH;
    end else begin
      state <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state;
    case (state)
      FETCH:   if (i_ibus_ack) state_d = IDLE;
      IDLE:    if (i_start) state_d = SHIFT;
      SHIFT:   if (cnt == CNT_LAST) state_d = misalign_hit ? IDLE : FETCH;
      default: state_d = FETCH;
    endcase
  end

  // PC datapath: snapshot on start, shift slices through, commit on the last slice
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ibus_adr <= RESET_PC;
      pc_sh      <= 32'd0;
      pc_acc     <= '0;
      cnt        <= '0;
      o_done     <= 1'b0;
    end else begin
      o_done <= ((state == FETCH) && i_ibus_ack) || misalign_hit;
      if (starting) begin
        pc_sh <= o_ibus_adr;
        cnt   <= '0;
      end else if (shifting) begin
        pc_sh  <= pc_sh >> W;
        pc_acc <= pc_new[31:W];
        cnt    <= cnt + 1'b1;
        if (last && !misalign_hit) begin
          o_ibus_adr <= pc_new;
        end
      end
    end
  end

`ifdef SERV_PC_CTRL_MISALIGN_EN
  // One-cycle flag accompanying the done pulse of a rejected jump
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_misalign <= 1'b0;
    end else begin
      o_misalign <= misalign_hit;
    end
  end
`endif

endmodule

// File: tb/tb_serv_pc_ctrl.sv
// tb/tb_serv_pc_ctrl.sv - randomized self-checking bench for serv_pc_ctrl against a word-level model
`timescale 1ns/1ps
module tb_serv_pc_ctrl;

  localparam int          W        = 4;
  localparam int          N        = 32 / W;
  localparam logic [31:0] RESET_PC = 32'h0000_0080;
  localparam bit          WITH_CSR = 1'b1;
`ifdef SERV_PC_CTRL_MISALIGN_EN
  localparam bit          WITH_C   = 1'b0;
  localparam bit          MIS_EN   = 1'b1;
`else
  localparam bit          WITH_C   = 1'b1;
  localparam bit          MIS_EN   = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         i_rst_n;
  logic         i_start, i_jump, i_jal_or_jalr, i_utype, i_pc_rel, i_trap, i_iscomp;
  logic [W-1:0] i_imm, i_buf, i_csr_pc;
  logic [W-1:0] o_rd, o_bad_pc;
  logic         o_busy, o_done, o_ibus_cyc, i_ibus_ack;
  logic [31:0]  o_ibus_adr;
`ifdef SERV_PC_CTRL_MISALIGN_EN
  logic         o_misalign;
`endif

  int           n_cmp = 0;
  int           n_err = 0;
  logic [31:0]  exp_pc;

  always #5 clk = ~clk;

  serv_pc_ctrl #(
    .W(W), .RESET_PC(RESET_PC), .WITH_CSR(WITH_CSR), .WITH_C(WITH_C)
  ) dut (
    .clk           (clk),
    .i_rst_n       (i_rst_n),
    .i_start       (i_start),
    .i_jump        (i_jump),
    .i_jal_or_jalr (i_jal_or_jalr),
    .i_utype       (i_utype),
    .i_pc_rel      (i_pc_rel),
    .i_trap        (i_trap),
    .i_iscomp      (i_iscomp),
    .i_imm         (i_imm),
    .i_buf         (i_buf),
    .i_csr_pc      (i_csr_pc),
    .o_rd          (o_rd),
    .o_bad_pc      (o_bad_pc),
`ifdef SERV_PC_CTRL_MISALIGN_EN
    .o_misalign    (o_misalign),
`endif
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_ibus_adr    (o_ibus_adr),
    .o_ibus_cyc    (o_ibus_cyc),
    .i_ibus_ack    (i_ibus_ack)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Whole-word reference of one PC update
  function automatic void model(
    input  logic [31:0] pc,
    input  logic jump, jal, utype, pc_rel, trap, iscomp,
    input  logic [31:0] imm, bufv, csr,
    output logic [31:0] npc, rd, bad,
    output logic mis);
    logic [31:0] pc4, a, b, tgt;
    pc4 = pc + ((WITH_C && iscomp) ? 32'd2 : 32'd4);
    a   = pc_rel ? pc : 32'd0;
    b   = utype ? (imm & 32'hFFFF_F000) : bufv;
    tgt = (a + b) & ~32'd1;
    npc = (WITH_CSR && trap) ? (csr & ~32'd3) : (jump ? tgt : pc4);
    rd  = (utype ? tgt : 32'd0) | (jal ? pc4 : 32'd0);
    bad = tgt;
    mis = MIS_EN && jump && !(WITH_CSR && trap) && !WITH_C && tgt[1];
  endfunction

  task automatic check_misalign(input string tag, input logic exp);
`ifdef SERV_PC_CTRL_MISALIGN_EN
    chk(tag, o_misalign, exp);
`else
    if (exp) $display("FAIL %s: misalign expected without feature", tag);
`endif
  endtask

  // FETCH phase: hold cyc for ack_dly cycles, then ack and expect the done pulse
  task automatic finish_fetch(input int ack_dly);
    for (int d = 0; d <= ack_dly; d++) begin
      i_ibus_ack = (d == ack_dly);
      @(negedge clk);
      chk("fetch_adr", o_ibus_adr, exp_pc);
      chk("fetch_cyc", o_ibus_cyc, 1);
      chk("fetch_busy", o_busy, 1);
      chk("fetch_done", o_done, 0);
      @(posedge clk); #1;
    end
    i_ibus_ack = 1'b0;
    @(negedge clk);
    chk("done_pulse", o_done, 1);
    chk("idle_busy", o_busy, 0);
    chk("idle_cyc", o_ibus_cyc, 0);
    check_misalign("idle_misalign", 0);
    @(posedge clk); #1;
    i_ibus_ack = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("done_once", o_done, 0);
    @(posedge clk); #1;
    i_ibus_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_ignored", o_busy, 0);
    chk("idle_adr", o_ibus_adr, exp_pc);
  endtask

  task automatic run_op(input logic jump, jal, utype, pc_rel, trap, iscomp,
                        input logic [31:0] imm, bufv, csr, input int ack_dly);
    logic [31:0] npc, rd, bad;
    logic        mis;
    model(exp_pc, jump, jal, utype, pc_rel, trap, iscomp, imm, bufv, csr, npc, rd, bad, mis);
    @(posedge clk); #1;
    i_start = 1'b1;
    i_jump = jump; i_jal_or_jalr = jal; i_utype = utype;
    i_pc_rel = pc_rel; i_trap = trap; i_iscomp = iscomp;
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) begin
      i_imm      = imm[k*W +: W];
      i_buf      = bufv[k*W +: W];
      i_csr_pc   = csr[k*W +: W];
      i_start    = ($urandom_range(0, 3) == 0);
      i_ibus_ack = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      chk("shift_busy", o_busy, 1);
      chk("shift_cyc", o_ibus_cyc, 0);
      chk("rd_slice", o_rd, rd[k*W +: W]);
      chk("bad_pc_slice", o_bad_pc, bad[k*W +: W]);
      @(posedge clk); #1;
    end
    i_start = 1'b0; i_ibus_ack = 1'b0;
    i_jump = 0; i_jal_or_jalr = 0; i_utype = 0; i_pc_rel = 0; i_trap = 0; i_iscomp = 0;
    if (mis) begin
      @(negedge clk);
      chk("mis_cyc", o_ibus_cyc, 0);
      chk("mis_busy", o_busy, 0);
      chk("mis_done", o_done, 1);
      chk("mis_adr", o_ibus_adr, exp_pc);
      check_misalign("mis_flag", 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("mis_done_once", o_done, 0);
      check_misalign("mis_flag_once", 0);
    end else begin
      exp_pc = npc;
      finish_fetch(ack_dly);
    end
  endtask

  task automatic set_pc(input logic [31:0] pc);
    run_op(1, 0, 0, 0, 0, 0, 32'd0, pc, 32'd0, 1);
  endtask

  initial begin
    i_rst_n = 1'b0; i_start = 0; i_jump = 0; i_jal_or_jalr = 0; i_utype = 0;
    i_pc_rel = 0; i_trap = 0; i_iscomp = 0; i_imm = '0; i_buf = '0; i_csr_pc = '0;
    i_ibus_ack = 0;
    exp_pc = RESET_PC;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_adr", o_ibus_adr, RESET_PC);
    chk("rst_cyc", o_ibus_cyc, 1);
    chk("rst_busy", o_busy, 1);
    chk("rst_done", o_done, 0);
    chk("rst_rd", o_rd, 0);
    chk("rst_bad_pc", o_bad_pc, 0);
    check_misalign("rst_misalign", 0);
    @(posedge clk); #1;
    i_rst_n = 1'b1;
    finish_fetch(2);

    // Sequential increment, then compressed increment
    set_pc(32'h0000_0100);
    run_op(0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0, 0);
    chk("inc4_pc", o_ibus_adr, 32'h0000_0104);
    run_op(0, 0, 0, 0, 0, 1, 32'd0, 32'd0, 32'd0, 1);
    chk("iscomp_pc", o_ibus_adr, WITH_C ? 32'h0000_0106 : 32'h0000_0108);

    // JAL
    set_pc(32'h0000_1000);
    run_op(1, 1, 0, 1, 0, 0, 32'd0, 32'h0000_0FF9, 32'd0, 2);
    chk("jal_pc", o_ibus_adr, 32'h0000_1FF8);

    // AUIPC
    set_pc(32'h0000_2000);
    run_op(0, 0, 1, 1, 0, 0, 32'h1234_5ABC, 32'hDEAD_BEEF, 32'd0, 0);
    chk("auipc_pc", o_ibus_adr, 32'h0000_2004);

    // Trap and wrap-around
    run_op(0, 0, 0, 0, 1, 0, 32'd0, 32'd0, 32'h8000_0003, 3);
    chk("trap_pc", o_ibus_adr, 32'h8000_0000);
    set_pc(32'hFFFF_FFFC);
    run_op(0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0, 0);
    chk("wrap_pc", o_ibus_adr, 32'h0000_0000);

    // Half-word aligned jump target
    set_pc(32'h0000_1000);
    run_op(1, 0, 0, 0, 0, 0, 32'd0, 32'h0000_1002, 32'd0, 1);
    chk("half_tgt_pc", o_ibus_adr, MIS_EN ? 32'h0000_1000 : 32'h0000_1002);

    // Random operations
    for (int r = 0; r < 40; r++) begin
      run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
             $urandom, $urandom, $urandom, $urandom_range(0, 3));
    end

    // Reset in the middle of SHIFT
    @(posedge clk); #1;
    i_start = 1'b1; i_jump = 1'b1; i_buf = '1;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    i_rst_n = 1'b0;
    #1;
    chk("abort_adr", o_ibus_adr, RESET_PC);
    chk("abort_cyc", o_ibus_cyc, 1);
    chk("abort_busy", o_busy, 1);
    chk("abort_done", o_done, 0);
    chk("abort_rd", o_rd, 0);
    @(posedge clk); #1;
    i_rst_n = 1'b1; i_jump = 1'b0; i_buf = '0;
    exp_pc = RESET_PC;
    finish_fetch(1);
    run_op(0, 1, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0, 0);
    chk("post_abort_pc", o_ibus_adr, RESET_PC + 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
